rc_sched: RTL
=============

Name: rc_sched

Overview:
- Per-token recompute scheduler for the core recompute datapath (scale multiply, arithmetic shift, round/saturate).
- Owns every control input of that datapath: `recompute_needed`, `rc_scale`, `rc_scale_vld`, `rc_scale_clear` and `rms_rc_shift`.
- Buffers per-token scales coming from the RMS reciprocal unit.
- Keeps a shadow model of the datapath's input FIFO, so each scale is applied to exactly `cfg_vec_len` FIFO reads, and back-to-back tokens switch scale with no bubble and no cross-token mixing.
- Sits between the normalization-statistics unit and each core's recompute datapath.

Parameters:
- `SCALE_WIDTH`, 16, width of the recompute scale.
- `SHIFT_WIDTH`, 5, width of the recompute shift.
- `VEC_LEN_WIDTH`, 12, width of the element count per token.
- `TOK_CNT_WIDTH`, 10, width of the token count per pass.
- `DP_FIFO_DEPTH`, 4, depth of the datapath input FIFO being modelled (power of two).
- `SCALE_Q_DEPTH`, 2, depth of the internal scale queue (power of two).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  pulse; latches all `cfg_*` inputs. Ignored unless in IDLE.
- `cfg_recompute_en`  in  1  1 = scale/shift mode, 0 = bypass.
- `cfg_shift`  in  `SHIFT_WIDTH`  shift for the pass; must be ≥1 when recompute is enabled.
- `cfg_vec_len`  in  `VEC_LEN_WIDTH`  elements per token; must be ≥1.
- `cfg_num_tokens`  in  `TOK_CNT_WIDTH`  tokens in the pass; must be ≥1.
- `scale_in`  in  `SCALE_WIDTH`  per-token scale.
- `scale_in_vld`  in  1  scale offer.
- `scale_in_rdy`  out  1  scale queue not full.
- `dp_in_vld`  in  1  copy of the datapath input valid.
- `dp_out_vld`  in  1  copy of the datapath output valid.
- `recompute_needed`  out  1  to datapath.
- `rc_scale`  out  `SCALE_WIDTH`  to datapath.
- `rc_scale_vld`  out  1  to datapath.
- `rc_scale_clear`  out  1  to datapath.
- `rms_rc_shift`  out  `SHIFT_WIDTH`  to datapath.
- `busy`  out  1  pass in progress.
- `token_done`  out  1  pulse when the last output of a token is seen.
- `pass_done`  out  1  pulse when the last output of the pass is seen.
- `error`  out  1  sticky error flag.

Behaviour:
- Reset clears all state, counters and the scale queue.
  - At reset all outputs are 0 and the state is IDLE.
  - Reset mid-pass abandons the pass; no `token_done` or `pass_done` is produced.
- Shadow FIFO model (registers `occ`, `avail`):
  - `wr` = `dp_in_vld` && `occ` != `DP_FIFO_DEPTH`.
  - `rd` = (`!recompute_needed` || `avail`) && `occ` != 0.
  - `occ` ← `occ` + `wr` − `rd`.
  - `dp_in_vld` with `occ` == `DP_FIFO_DEPTH` sets `error`.
- Scale queue: push on `scale_in_vld` && `scale_in_rdy`.
  - A simultaneous push and pop are both allowed.
  - `scale_in_vld` while the queue is full is dropped and sets `error`.
- `recompute_needed` and `rms_rc_shift` are registered from cfg on `start` and held until the next `start`.
- `rc_scale`, `rc_scale_vld` and `rc_scale_clear` are combinational from registered state only. `rc_scale` = queue head.
- States:
  - IDLE: `busy`=0. On `start`, latch cfg, zero the counters and `avail`. Go to LOAD if recompute is enabled, else to BYPASS.
  - LOAD: when the queue is non-empty, assert `rc_scale_vld` (pop, `avail`←1, `rd_cnt`←0), then go to RUN.
  - RUN: `rd_cnt` += `rd`. In the cycle where `rd` is true and `rd_cnt` == `cfg_vec_len`−1 (final read of the token):
    - if tokens issued < `cfg_num_tokens` and the queue is non-empty: assert `rc_scale_vld` with the next scale (no clear; `avail` stays 1, `rd_cnt`←0), stay in RUN;
    - else if tokens issued < `cfg_num_tokens` and the queue is empty: assert `rc_scale_clear`, `avail`←0, go to LOAD;
    - else (last token): assert `rc_scale_clear`, `avail`←0, go to DRAIN.
  - BYPASS: the datapath reads freely. Go to DRAIN once the output count reaches `cfg_vec_len`·`cfg_num_tokens`.
  - DRAIN: wait for `pass_done`, then go to IDLE.
- Output tracking runs in every non-IDLE state.
  - `out_cnt` counts `dp_out_vld` and wraps at `cfg_vec_len`.
  - `token_done` pulses on the wrap.
  - `pass_done` pulses on the wrap of token `cfg_num_tokens` and coincides with that token's `token_done`.
- `dp_out_vld` while in IDLE sets `error`.
- `error` clears only on reset.

Decomposition:
- Package `rc_sched_pkg` holds:
  - the state enum `rc_sched_state_e` {IDLE, LOAD, RUN, BYPASS, DRAIN};
  - default width constants mirroring the recompute scale/shift widths.
- Sub-module `rc_scale_queue`: a parameterised synchronous FIFO with `push`, `pop`, `head`, `empty` and `full` outputs, and a combinational head.

Test Plan:
- Recompute, vec_len=4, tokens=1, scale 0x0100 queued before `start`, 4 inputs → one `rc_scale_vld` at LOAD; `rc_scale_clear` in the cycle of the 4th shadow read; `token_done` and `pass_done` pulse together on the 4th `dp_out_vld`.
- Recompute, vec_len=3, tokens=2, scales 0x0080 and 0x0200 both queued, 6 back-to-back inputs → second `rc_scale_vld` in the same cycle as read 3; no `rc_scale_clear` between tokens; `rc_scale_clear` only after read 6.
- Second scale arrives 10 cycles late → `rc_scale_clear` after read 3, state LOAD, `avail`=0 so no reads happen; `rc_scale_vld` the cycle after the scale is pushed; reads then resume.
- Bypass, vec_len=2, tokens=3 → `recompute_needed`=0; no scale strobes; `pass_done` on the 6th `dp_out_vld`; back to IDLE.
- Five `dp_in_vld` with no scale (DP_FIFO_DEPTH=4) → `error`=1 on the 5th and stays set; three scale pushes into the 2-deep queue with no pops → `error`=1.
- `rst`=1 while in RUN with tokens remaining → next cycle all outputs are 0, state IDLE, queue empty; a following `start` runs a clean pass.

Source files
------------

// File: rtl/rc_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rc_sched_pkg
// Description : Shared types and default widths for the recompute scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package rc_sched_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RUN    = 3'd2,
        BYPASS = 3'd3,
        DRAIN  = 3'd4
    } rc_sched_state_e;

    // Defaults track the recompute datapath's scale and shift widths
    localparam int RC_SCALE_WIDTH = 16;
    localparam int RC_SHIFT_WIDTH = 5;

endpackage
`default_nettype wire

// File: rtl/rc_scale_queue.sv
`default_nettype none
// ============================================================================
// Module      : rc_scale_queue
// Description : Small synchronous FIFO holding per-token scales; head is
//               combinational so the scheduler can present it immediately.
// Revision    : 1.0 - initial release
// ============================================================================
module rc_scale_queue
    import rc_sched_pkg::*;
#(
    parameter int WIDTH = RC_SCALE_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign empty  = (r_count == '0);
    assign full   = (r_count == CNT_W'(DEPTH));
    assign head   = r_mem[r_rd_ptr];

    // Storage is cleared too so the head reads zero out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/rc_sched.sv
`default_nettype none
// ============================================================================
// Module      : rc_sched
// Description : Per-token recompute scheduler; tracks the datapath input FIFO
//               so each scale covers exactly one token of reads.
// Revision    : 1.0 - initial release
// ============================================================================
module rc_sched
    import rc_sched_pkg::*;
#(
    parameter int SCALE_WIDTH   = RC_SCALE_WIDTH,
    parameter int SHIFT_WIDTH   = RC_SHIFT_WIDTH,
    parameter int VEC_LEN_WIDTH = 12,
    parameter int TOK_CNT_WIDTH = 10,
    parameter int DP_FIFO_DEPTH = 4,
    parameter int SCALE_Q_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     cfg_recompute_en,
    input  logic [SHIFT_WIDTH-1:0]   cfg_shift,
    input  logic [VEC_LEN_WIDTH-1:0] cfg_vec_len,
    input  logic [TOK_CNT_WIDTH-1:0] cfg_num_tokens,
    input  logic [SCALE_WIDTH-1:0]   scale_in,
    input  logic                     scale_in_vld,
    output logic                     scale_in_rdy,
    input  logic                     dp_in_vld,
    input  logic                     dp_out_vld,
    output logic                     recompute_needed,
    output logic [SCALE_WIDTH-1:0]   rc_scale,
    output logic                     rc_scale_vld,
    output logic                     rc_scale_clear,
    output logic [SHIFT_WIDTH-1:0]   rms_rc_shift,
    output logic                     busy,
    output logic                     token_done,
    output logic                     pass_done,
    output logic                     error
);

    localparam int OCC_W = $clog2(DP_FIFO_DEPTH + 1);

    rc_sched_state_e          r_state;
    rc_sched_state_e          w_state_nxt;
    logic                     r_recompute_needed;
    logic [SHIFT_WIDTH-1:0]   r_shift;
    logic [VEC_LEN_WIDTH-1:0] r_vec_len;
    logic [TOK_CNT_WIDTH-1:0] r_num_tokens;
    logic [OCC_W-1:0]         r_occ;
    logic                     r_avail;
    logic [VEC_LEN_WIDTH-1:0] r_rd_cnt;
    logic [TOK_CNT_WIDTH-1:0] r_tok_issued;
    logic [VEC_LEN_WIDTH-1:0] r_out_cnt;
    logic [TOK_CNT_WIDTH-1:0] r_tok_out;
    logic                     r_out_done;
    logic                     r_error;

    logic                     w_wr;
    logic                     w_rd;
    logic                     w_final_rd;
    logic                     w_more;
    logic                     w_active;
    logic                     w_out_wrap;
    logic                     w_pop;
    logic                     w_q_empty;
    logic                     w_q_full;
    logic [SCALE_WIDTH-1:0]   w_q_head;

    rc_scale_queue #(
        .WIDTH (SCALE_WIDTH),
        .DEPTH (SCALE_Q_DEPTH)
    ) u_scale_q (
        .clk   (clk),
        .rst   (rst),
        .push  (scale_in_vld && scale_in_rdy),
        .pop   (w_pop),
        .din   (scale_in),
        .head  (w_q_head),
        .empty (w_q_empty),
        .full  (w_q_full)
    );

    // Shadow of the datapath input FIFO: reads stall while no scale is held
    assign w_wr       = dp_in_vld && (r_occ != OCC_W'(DP_FIFO_DEPTH));
    assign w_rd       = (!r_recompute_needed || r_avail) && (r_occ != '0);
    assign w_final_rd = (r_state == RUN) && w_rd && (r_rd_cnt == r_vec_len - VEC_LEN_WIDTH'(1));
    assign w_more     = (r_tok_issued < r_num_tokens);

    assign w_active   = (r_state != IDLE) && !rst;
    assign w_out_wrap = w_active && !r_out_done && dp_out_vld
                        && (r_out_cnt == r_vec_len - VEC_LEN_WIDTH'(1));
    assign token_done = w_out_wrap;
    assign pass_done  = w_out_wrap && (r_tok_out == r_num_tokens - TOK_CNT_WIDTH'(1));

    assign scale_in_rdy     = !w_q_full && !rst;
    assign recompute_needed = r_recompute_needed;
    assign rms_rc_shift     = r_shift;
    assign rc_scale         = w_q_head;
    assign busy             = (r_state != IDLE);
    assign error            = r_error;

    always_comb begin
        w_state_nxt    = r_state;
        w_pop          = 1'b0;
        rc_scale_vld   = 1'b0;
        rc_scale_clear = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = cfg_recompute_en ? LOAD : BYPASS;
                end
            end
            LOAD: begin
                if (!w_q_empty) begin
                    rc_scale_vld = 1'b1;
                    w_pop        = 1'b1;
                    w_state_nxt  = RUN;
                end
            end
            RUN: begin
                // Next scale lands on the final read so tokens abut with no bubble
                if (w_final_rd) begin
                    if (w_more && !w_q_empty) begin
                        rc_scale_vld = 1'b1;
                        w_pop        = 1'b1;
                    end else begin
                        rc_scale_clear = 1'b1;
                        w_state_nxt    = w_more ? LOAD : DRAIN;
                    end
                end
            end
            BYPASS: begin
                if (pass_done || r_out_done) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pass_done || r_out_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state            <= IDLE;
            r_recompute_needed <= 1'b0;
            r_shift            <= '0;
            r_vec_len          <= '0;
            r_num_tokens       <= '0;
            r_occ              <= '0;
            r_avail            <= 1'b0;
            r_rd_cnt           <= '0;
            r_tok_issued       <= '0;
            r_out_cnt          <= '0;
            r_tok_out          <= '0;
            r_out_done         <= 1'b0;
            r_error            <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_occ   <= r_occ + OCC_W'(w_wr) - OCC_W'(w_rd);

            if ((dp_in_vld && !w_wr) || (scale_in_vld && w_q_full)
                || (dp_out_vld && (r_state == IDLE))) begin
                r_error <= 1'b1;
            end

            if ((r_state == IDLE) && start) begin
                r_recompute_needed <= cfg_recompute_en;
                r_shift            <= cfg_shift;
                r_vec_len          <= cfg_vec_len;
                r_num_tokens       <= cfg_num_tokens;
                r_avail            <= 1'b0;
                r_rd_cnt           <= '0;
                r_tok_issued       <= '0;
                r_out_cnt          <= '0;
                r_tok_out          <= '0;
                r_out_done         <= 1'b0;
            end

            if (rc_scale_vld) begin
                r_avail      <= 1'b1;
                r_rd_cnt     <= '0;
                r_tok_issued <= r_tok_issued + TOK_CNT_WIDTH'(1);
            end else if (rc_scale_clear) begin
                r_avail  <= 1'b0;
                r_rd_cnt <= '0;
            end else if ((r_state == RUN) && w_rd) begin
                r_rd_cnt <= r_rd_cnt + VEC_LEN_WIDTH'(1);
            end

            if (w_active && dp_out_vld && !r_out_done) begin
                if (w_out_wrap) begin
                    r_out_cnt <= '0;
                    r_tok_out <= r_tok_out + TOK_CNT_WIDTH'(1);
                    if (pass_done) begin
                        r_out_done <= 1'b1;
                    end
                end else begin
                    r_out_cnt <= r_out_cnt + VEC_LEN_WIDTH'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire
